// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: APB completer holding a bank of G_NUM_REGS read/write registers.
//
// Parameters:
//   G_REGWIDTH    - data width in bits (multiple of 8)
//   G_ADDR_WIDTH  - paddr width
//   G_NUM_REGS    - number of registers (power of 2, >= 2)
//   G_WAIT_STATES - access-phase cycles with pready low before completion (0..15)
//
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   s_apb_psel/penable/pwrite    - APB control
//   s_apb_pprot                  - protection attributes
//   s_apb_paddr/pwdata/pstrb     - APB address, write data, byte strobes
//   s_apb_pready/prdata/pslverr  - APB response
//   reg_q                        - flat register contents, reg i at [i*G_REGWIDTH +: G_REGWIDTH]
//   reg_wr                       - one-cycle pulse per register, the cycle after it is written
//
// Optional build macro APB_REGFILE_PROT_EN: unprivileged accesses (pprot[0]=0) to the upper half
// of the bank complete with pslverr and have no effect. Without it pprot is ignored.
module apb_regfile_slave #(
   parameter int unsigned G_REGWIDTH    = 32,
   parameter int unsigned G_ADDR_WIDTH  = 32,
   parameter int unsigned G_NUM_REGS    = 16,
   parameter int unsigned G_WAIT_STATES = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             s_apb_psel,
   input  logic                             s_apb_penable,
   input  logic                             s_apb_pwrite,
   input  logic [2:0]                       s_apb_pprot,
   input  logic [G_ADDR_WIDTH-1:0]          s_apb_paddr,
   input  logic [G_REGWIDTH-1:0]            s_apb_pwdata,
   input  logic [G_REGWIDTH/8-1:0]          s_apb_pstrb,
   output logic                             s_apb_pready,
   output logic [G_REGWIDTH-1:0]            s_apb_prdata,
   output logic                             s_apb_pslverr,
   output logic [G_NUM_REGS*G_REGWIDTH-1:0] reg_q,
   output logic [G_NUM_REGS-1:0]            reg_wr
);

   localparam int unsigned Bytes      = G_REGWIDTH / 8;
   localparam int unsigned AddrLsb    = $clog2(Bytes);
   localparam int unsigned IdxW       = $clog2(G_NUM_REGS);
   localparam int unsigned RangeBytes = G_NUM_REGS * Bytes;

   typedef enum logic {StIdle, StAccess} state_e;

   state_e                  state_q, state_d;
   logic [3:0]              wait_q, wait_d;
   logic [G_REGWIDTH-1:0]   regs_q [G_NUM_REGS];
   logic [G_REGWIDTH-1:0]   regs_d [G_NUM_REGS];
   logic [G_NUM_REGS-1:0]   reg_wr_q, reg_wr_d;

   logic [IdxW-1:0] idx;
   logic            in_range;
   logic            prot_err;
   logic            access_ok;
   logic            wr_en;
   logic            unused_prot;

   // Low address bits below AddrLsb are simply not decoded, so misaligned accesses hit the word.
   assign idx      = s_apb_paddr[AddrLsb +: IdxW];
   assign in_range = s_apb_paddr < G_ADDR_WIDTH'(RangeBytes);

`ifdef APB_REGFILE_PROT_EN
   assign prot_err = ~s_apb_pprot[0] & idx[IdxW-1];
`else
   assign prot_err = 1'b0;
`endif
   assign unused_prot = ^s_apb_pprot;

   assign access_ok = in_range & ~prot_err;

   // Handshake FSM; pready is combinational so a zero-wait transfer finishes in two cycles.
   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      s_apb_pready = 1'b0;
      unique case (state_q)
         StIdle: begin
            // psel with penable but no prior setup phase is ignored here.
            if (s_apb_psel && !s_apb_penable) begin
               state_d = StAccess;
               wait_d  = 4'(G_WAIT_STATES);
            end
         end
         StAccess: begin
            if (!s_apb_psel) begin
               state_d = StIdle;
            end else if (s_apb_penable) begin
               if (wait_q != 4'd0) begin
                  wait_d = wait_q - 4'd1;
               end else begin
                  s_apb_pready = 1'b1;
                  state_d      = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign wr_en         = s_apb_pready & s_apb_pwrite & access_ok;
   assign s_apb_pslverr = s_apb_pready & ~access_ok;
   assign s_apb_prdata  = (s_apb_pready && !s_apb_pwrite && access_ok) ? regs_q[idx] : '0;

   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         for (int k = 0; k < int'(Bytes); k++) begin
            if (s_apb_pstrb[k]) begin
               regs_d[idx][k*8 +: 8] = s_apb_pwdata[k*8 +: 8];
            end
         end
      end
   end

   // Strobe fires even for an all-zero pstrb write.
   assign reg_wr_d = wr_en ? (G_NUM_REGS'(1) << idx) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         wait_q   <= 4'd0;
         reg_wr_q <= '0;
         for (int i = 0; i < int'(G_NUM_REGS); i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         reg_wr_q <= reg_wr_d;
         regs_q   <= regs_d;
      end
   end

   for (genvar g = 0; g < int'(G_NUM_REGS); g++) begin : g_flat
      assign reg_q[g*G_REGWIDTH +: G_REGWIDTH] = regs_q[g];
   end

   assign reg_wr = reg_wr_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
module tb_apb_regfile_slave;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         sel = 1'b0;  // 0: zero-wait instance, 1: three-wait instance
   logic         psel = 1'b0;
   logic         penable = 1'b0;
   logic         pwrite = 1'b0;
   logic [2:0]   pprot = 3'b001;
   logic [31:0]  paddr = '0;
   logic [31:0]  pwdata = '0;
   logic [3:0]   pstrb = '0;

   logic         pready0, pready1, pslverr0, pslverr1;
   logic [31:0]  prdata0, prdata1;
   logic [511:0] regq0, regq1;
   logic [15:0]  regwr0, regwr1;

   logic         pready, pslverr;
   logic [31:0]  prdata;
   logic [511:0] regq;
   logic [15:0]  regwr;

   int n_asserts = 0;
   int n_fails   = 0;

   logic [31:0] mdl [2][16];

   always #5 clk = ~clk;

   apb_regfile_slave #(.G_WAIT_STATES(0)) u_dut0 (
      .clk(clk), .rst(rst), .s_apb_psel(psel & ~sel), .s_apb_penable(penable),
      .s_apb_pwrite(pwrite), .s_apb_pprot(pprot), .s_apb_paddr(paddr), .s_apb_pwdata(pwdata),
      .s_apb_pstrb(pstrb), .s_apb_pready(pready0), .s_apb_prdata(prdata0),
      .s_apb_pslverr(pslverr0), .reg_q(regq0), .reg_wr(regwr0)
   );

   apb_regfile_slave #(.G_WAIT_STATES(3)) u_dut1 (
      .clk(clk), .rst(rst), .s_apb_psel(psel & sel), .s_apb_penable(penable),
      .s_apb_pwrite(pwrite), .s_apb_pprot(pprot), .s_apb_paddr(paddr), .s_apb_pwdata(pwdata),
      .s_apb_pstrb(pstrb), .s_apb_pready(pready1), .s_apb_prdata(prdata1),
      .s_apb_pslverr(pslverr1), .reg_q(regq1), .reg_wr(regwr1)
   );

   assign pready  = sel ? pready1  : pready0;
   assign pslverr = sel ? pslverr1 : pslverr0;
   assign prdata  = sel ? prdata1  : prdata0;
   assign regq    = sel ? regq1    : regq0;
   assign regwr   = sel ? regwr1   : regwr0;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s dut%0d: got %0h expected %0h", tag, sel, obs, exp);
      end
   endtask

   function automatic logic [511:0] flat(input int d);
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = mdl[d][i];
      return v;
   endfunction

   task automatic clear_models();
      for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) mdl[d][i] = '0;
   endtask

   // One complete APB transfer on the instance picked by d, checked against the model.
   task automatic xfer(input logic d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot);
      int          ws, lows, idx;
      bit          done, ok;
      logic [31:0] exp_rd;
      logic [15:0] exp_wr;
      ws  = d ? 3 : 0;
      idx = int'(addr[5:2]);
      ok  = addr < 32'd64;
`ifdef APB_REGFILE_PROT_EN
      if (!prot[0] && idx >= 8) ok = 1'b0;
`endif
      @(posedge clk); #1;
      sel = d; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
      pwdata = data; pstrb = strb; pprot = prot;
      @(negedge clk);
      check("setup_pready", pready, 0);
      check("setup_prdata", prdata, 0);
      @(posedge clk); #1;
      penable = 1'b1;
      lows = 0; done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (pready === 1'b1) done = 1;
         else begin
            if (pslverr !== 1'b0) check("pslverr_while_wait", pslverr, 0);
            lows++;
            @(posedge clk); #1;
         end
      end
      check("completed", done, 1);
      check("wait_cycles", lows, ws);
      exp_rd = (!wr && ok) ? mdl[d][idx] : 32'h0;
      check("pslverr", pslverr, !ok);
      check("prdata", prdata, exp_rd);
      exp_wr = '0;
      if (wr && ok) begin
         for (int k = 0; k < 4; k++) if (strb[k]) mdl[d][idx][k*8 +: 8] = data[k*8 +: 8];
         exp_wr = 16'(1) << idx;
      end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      check("reg_wr_pulse", regwr, exp_wr);
      check("reg_q", regq, flat(d));
      @(posedge clk); #1;
      check("reg_wr_clear", regwr, 0);
   endtask

   initial begin
      clear_models();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         sel = d[0];
         #1;
         check("rst_pready", pready, 0);
         check("rst_prdata", prdata, 0);
         check("rst_pslverr", pslverr, 0);
         check("rst_reg_q", regq, 0);
         check("rst_reg_wr", regwr, 0);
      end

      // Reset contents, zero-wait instance.
      for (int i = 0; i < 16; i++) xfer(1'b0, 1'b0, 32'(i * 4), 32'h0, 4'h0, 3'b001);

      xfer(1'b0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 3'b001);
      xfer(1'b0, 1'b0, 32'h08, 32'h0, 4'h0, 3'b001);
      check("reg2_value", regq0[95:64], 32'hDEADBEEF);
      xfer(1'b0, 1'b1, 32'h08, 32'h11223344, 4'h5, 3'b001);
      xfer(1'b0, 1'b0, 32'h08, 32'h0, 4'h0, 3'b001);
      check("reg2_merged", regq0[95:64], 32'hDE22BE44);
      xfer(1'b0, 1'b1, 32'h0C, 32'hCAFEF00D, 4'h0, 3'b001);  // zero strobe: pulse, no change

      // Three-wait instance.
      xfer(1'b1, 1'b1, 32'h04, 32'h00000004, 4'hF, 3'b001);
      xfer(1'b1, 1'b0, 32'h04, 32'h0, 4'h0, 3'b001);
      xfer(1'b0, 1'b1, 32'h40, 32'h55AA55AA, 4'hF, 3'b001);
      xfer(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 3'b001);
      xfer(1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF, 3'b000);
      xfer(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000);

      // penable without setup from idle is ignored.
      @(posedge clk); #1;
      sel = 1'b0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h10; pstrb = 4'hF;
      repeat (2) begin
         @(negedge clk);
         check("no_setup_pready", pready, 0);
         @(posedge clk); #1;
      end
      psel = 1'b0; penable = 1'b0;
      check("no_setup_reg_q", regq, flat(0));

      // Abort mid-wait on the three-wait instance.
      @(posedge clk); #1;
      sel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C;
      pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
      @(posedge clk); #1 penable = 1'b1;
      @(negedge clk);
      check("abort_wait_pready", pready, 0);
      @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("abort_pready", pready, 0);
      end
      check("abort_reg_q", regq, flat(1));
      check("abort_reg_wr", regwr, 0);

      // Reset during the access phase.
      @(posedge clk); #1;
      sel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00;
      pwdata = 32'h0BADF00D; pstrb = 4'hF;
      @(posedge clk); #1 penable = 1'b1;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0; psel = 1'b0; penable = 1'b0;
      clear_models();
      check("midrst_reg_q1", regq1, 0);
      check("midrst_reg_q0", regq0, 0);
      check("midrst_pready", pready, 0);
      xfer(1'b1, 1'b1, 32'h3C, 32'hA5A5A5A5, 4'hF, 3'b001);
      xfer(1'b1, 1'b0, 32'h3C, 32'h0, 4'h0, 3'b001);

      // Randomised traffic, both instances, including misaligned and out-of-range addresses.
      for (int n = 0; n < 80; n++) begin
         xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 79)),
              $urandom, 4'($urandom), 3'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule

// File: doc/apb_regfile_slave.md
Name: apb_regfile_slave

Overview:
- APB completer that consumes the master-side APB bus of the APB pass-through stage: a bank of G_NUM_REGS read/write registers.
- Parameterised wait-state insertion exercises pready back-pressure.
- PSLVERR response on out-of-range addresses.
- Register contents exported as a flat bus, plus per-register write strobes, for downstream logic.

Parameters:
- G_REGWIDTH, 32: data width in bits; multiple of 8.
- G_ADDR_WIDTH, 32: paddr width.
- G_NUM_REGS, 16: number of registers; power of 2, ≥2.
- G_WAIT_STATES, 0: access-phase cycles with pready=0 before completion; 0..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_apb_psel  in  1  select
- s_apb_penable  in  1  enable/access phase
- s_apb_pwrite  in  1  1=write 0=read
- s_apb_pprot  in  3  protection attributes
- s_apb_paddr  in  G_ADDR_WIDTH  byte address
- s_apb_pwdata  in  G_REGWIDTH  write data
- s_apb_pstrb  in  G_REGWIDTH/8  byte write strobes
- s_apb_pready  out  1  transfer complete
- s_apb_prdata  out  G_REGWIDTH  read data
- s_apb_pslverr  out  1  error response
- reg_q  out  G_NUM_REGS*G_REGWIDTH  register contents; reg i at bits [i*G_REGWIDTH +: G_REGWIDTH]
- reg_wr  out  G_NUM_REGS  one-cycle pulse, bit i set the cycle after reg i is written

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset: all registers 0, reg_wr=0, FSM=IDLE, wait counter 0, pready=0, prdata=0, pslverr=0.
- Decode:
  - ADDR_LSB = log2(G_REGWIDTH/8); index = paddr[ADDR_LSB +: log2(G_NUM_REGS)].
  - paddr[ADDR_LSB-1:0] ignored (misaligned addresses are word-aligned).
  - Address in range iff paddr < G_NUM_REGS*(G_REGWIDTH/8).
- FSM states IDLE, ACCESS.
- IDLE:
  - psel=1, penable=0 (setup phase): capture nothing; load wait_cnt=G_WAIT_STATES; go ACCESS.
  - psel=1, penable=1 without a prior setup: ignored, pready stays 0, remain IDLE.
- ACCESS:
  - psel=0: abort; go IDLE, no write, no response.
  - psel=1, penable=1, wait_cnt>0: decrement wait_cnt, pready=0.
  - psel=1, penable=1, wait_cnt=0: pready=1 this cycle (combinational from state/counter/psel/penable); go IDLE on next edge.
- Latency:
  - G_WAIT_STATES=0: pready high in the first access cycle (transfer takes 2 cycles).
  - General case: 2+G_WAIT_STATES cycles.
- Write completion (pready=1, pwrite=1, in range): on that edge, byte k of reg[index] is updated iff pstrb[k]=1; reg_wr[index] pulses for one cycle next cycle. pstrb=0 is a legal no-op write, but reg_wr still pulses.
- Read completion: prdata = reg[index] while pready=1; prdata=0 at all other times.
- Out of range: pslverr=1 with pready; no register modified; reg_wr not pulsed; prdata=0.
- pslverr is 0 whenever pready=0.
- Back-to-back: a new setup phase on the cycle after completion is accepted (IDLE reached).
- Reset mid-transfer: FSM to IDLE, registers cleared, pending write discarded; master must restart.
- Address, pwrite, pwdata and pstrb are sampled at completion; they are required stable through the access phase per APB and are not checked.

Optional Feature:
- Macro: APB_REGFILE_PROT_EN.
- Defined: accesses with pprot[0]=0 (unprivileged) to the upper half of the register bank (index ≥ G_NUM_REGS/2) complete with pslverr=1. Writes are ignored and read data is 0.
- Not defined: pprot is ignored entirely.

Test Plan:
- Reset then read all regs (G_WAIT_STATES=0) -> each read completes in 2 cycles, prdata=0x00000000, pslverr=0.
- Write 0xDEADBEEF to addr 0x08, pstrb=0xF; read 0x08 -> prdata=0xDEADBEEF, reg_q[95:64]=0xDEADBEEF, reg_wr=0x0004 for one cycle.
- Write 0x11223344 to 0x08 with pstrb=0x5 over the previous value -> read 0x08 returns 0xDE22BE44.
- G_WAIT_STATES=3, write then read addr 0x04 -> pready low exactly 3 access cycles then high 1; transfer 5 cycles; data 0x04 round-trips.
- Write to addr 0x40 (16 regs × 4 B) -> pslverr=1 with pready, reg_q unchanged, reg_wr=0; read 0x40 -> prdata=0, pslverr=1.
- psel dropped mid-wait (G_WAIT_STATES=3) on write to 0x0C -> no pready, reg 3 unchanged. rst asserted during ACCESS -> all regs 0, next transfer completes normally. With APB_REGFILE_PROT_EN, pprot=3'b000 write to 0x20 -> pslverr=1, reg 8 unchanged.
